rca_config_bank: RTL and testbench
==================================

# rca_config_bank

Double-buffered, multi-RCA configuration store for the reconfigurable custom accelerators (RCAs). Each RCA has a shadow bank that config instructions write through a valid/ready port, and an active bank that drives the grid. A per-RCA commit state machine copies shadow to active only after all in-flight use instructions on that RCA have drained. It sits between decode/issue, which receives the config and use instruction streams, and the RCA grid/result-mux logic that consumes active config.

## Interface
Parameters:
- NUM_RCAS, 4, number of RCAs (each with its own bank pair)
- NUM_READ_PORTS, 5, CPU source registers per RCA
- NUM_WRITE_PORTS, 2, CPU destination registers / result muxes per RCA
- NUM_GRID_MUXES, 16, grid mux select registers
- GRID_MUX_INPUTS, 8, inputs per grid mux
- GRID_NUM_ROWS, 4, IO units / rows
- IO_UNIT_MUX_INPUTS, 4, inputs per IO unit mux
- XLEN, 32, data width
- MAX_INFLIGHT, 7, max outstanding uses per RCA (counter width clog2(MAX_INFLIGHT+1))

Ports:
- clk in 1 clock
- rst in 1 asynchronous, active-high reset
- cfg_valid in 1 config write request
- cfg_ready out 1 config write accepted when high with cfg_valid
- cfg_rca in clog2(NUM_RCAS) target RCA
- cfg_field in 3 rca_cfg_field_t
- cfg_addr in CFG_ADDR_W element index within field
- cfg_data in XLEN write data (low bits used)
- cfg_err out 1 one-cycle pulse: dropped write
- commit_req in 1 commit shadow→active pulse
- commit_rca in clog2(NUM_RCAS) RCA to commit
- commit_pending out NUM_RCAS per-RCA pending flag
- use_issue in 1 use instruction issued
- use_rca in clog2(NUM_RCAS) its RCA
- use_ready out 1 issue permitted for use_rca
- use_complete in 1 use instruction retired
- complete_rca in clog2(NUM_RCAS) its RCA
- rd_rca in clog2(NUM_RCAS) RCA whose active config is output
- active_cfg out rca_active_cfg_t active bank of rd_rca (combinational read of registers)

## Operation
- Fields: SRC_REG (addr<NUM_READ_PORTS, data[4:0]), DEST_REG (<NUM_WRITE_PORTS, [4:0]), GRID_MUX (<NUM_GRID_MUXES, clog2(GRID_MUX_INPUTS) bits), IO_MUX (<GRID_NUM_ROWS), RESULT_MUX (<NUM_WRITE_PORTS, clog2(GRID_NUM_ROWS) bits), IO_INP_MAP (whole GRID_NUM_ROWS-bit vector, addr ignored), INPUT_CONST (<GRID_NUM_ROWS, full XLEN); code 7 reserved.
- Accepted write with addr out of range or reserved field: storage unchanged, cfg_err pulses.
- Writes only touch shadow; active changes only via commit.
- Per-RCA in-flight counter: +1 on use_issue, −1 on use_complete, both same RCA same cycle → unchanged. use_complete at zero ignored.
- use_ready = !commit_pending[use_rca] && count[use_rca] < MAX_INFLIGHT.
- Per-RCA commit FSM: IDLE → PENDING on commit_req; PENDING → IDLE with full shadow→active copy on the edge where count==0 (registered value). commit_req while PENDING is merged (no effect).
- cfg_ready = !(commit_pending[cfg_rca] && count[cfg_rca]==0), so no write collides with the copy.

## Timing
- Reset: all shadow/active fields 0, counters 0, FSMs IDLE, commit_pending 0, cfg_err 0; cfg_ready and use_ready 1.
- Write accepted at edge E: shadow updated at E; cfg_err high the cycle after E.
- commit_req at edge E with count 0: commit_pending high after E, copy at E+1, new active_cfg visible after E+1, pending low after E+1.
- Nonzero count: copy at first edge after count registers 0.
- commit_req and accepted use_issue same RCA same cycle: use counted, commit waits for its completion.
- commit_req and cfg write same RCA same cycle: write included in copy.
- Reset mid-commit: bank contents and pending cleared immediately.

## Structure
- Add rca_cfg_field_t, rca_active_cfg_t and CFG_ADDR_W (clog2 of max element count) to the shared taiga_types package; parameters mirror rca_config.
- One sub-module, rca_cfg_bank_pair: shadow/active registers plus copy, instantiated NUM_RCAS times; commit FSMs and counters in the top.

## Test plan
- Reset, write INPUT_CONST rca1 addr2 data 0xDEADBEEF, commit → active_cfg (rd_rca=1) const[2]=0xDEADBEEF exactly two cycles after commit_req; rca0 unchanged.
- Write GRID_MUX addr NUM_GRID_MUXES and field 7 → cfg_err pulses each time, no storage change.
- Issue 3 uses on rca2, commit_req → pending held, use_ready low for rca2; after third completion, copy next edge.
- Issue to MAX_INFLIGHT (7) on rca0 → use_ready low; simultaneous issue+complete keeps count 7.
- commit_req with count 0 and cfg write same RCA same cycle → cfg_ready low in copy cycle, write accepted next cycle lands only in shadow.
- Assert rst while rca3 pending with count 2 → all outputs at reset values next cycle.

Source files
------------

// File: rtl/rca_config_bank_pkg.sv
// rca_config_bank_pkg: shared sizes, field codes and active-config layout for the RCA config bank
package rca_config_bank_pkg;
  localparam int NUM_RCAS = 4;
  localparam int NUM_READ_PORTS = 5;
  localparam int NUM_WRITE_PORTS = 2;
  localparam int NUM_GRID_MUXES = 16;
  localparam int GRID_MUX_INPUTS = 8;
  localparam int GRID_NUM_ROWS = 4;
  localparam int IO_UNIT_MUX_INPUTS = 4;
  localparam int XLEN = 32;
  localparam int MAX_INFLIGHT = 7;
  localparam int RCA_W = $clog2(NUM_RCAS);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int GM_W = $clog2(GRID_MUX_INPUTS);
  localparam int IOM_W = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int RM_W = $clog2(GRID_NUM_ROWS);
  localparam int SRC_AW = $clog2(NUM_READ_PORTS);
  localparam int WP_AW = $clog2(NUM_WRITE_PORTS);
  localparam int GM_AW = $clog2(NUM_GRID_MUXES);
  localparam int ROW_AW = $clog2(GRID_NUM_ROWS);
  // one extra bit so a one-past-the-end index of the largest field is still expressible and rejected
  localparam int CFG_ADDR_W = $clog2(NUM_GRID_MUXES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  typedef enum logic [2:0] {
    SRC_REG, DEST_REG, GRID_MUX, IO_MUX, RESULT_MUX, IO_INP_MAP, INPUT_CONST, RESERVED
  } rca_cfg_field_t;
  typedef enum logic {IDLE, PENDING} commit_state_t;
  typedef struct packed {
    logic [NUM_READ_PORTS-1:0][4:0] src_reg;
    logic [NUM_WRITE_PORTS-1:0][4:0] dest_reg;
    logic [NUM_GRID_MUXES-1:0][GM_W-1:0] grid_mux;
    logic [GRID_NUM_ROWS-1:0][IOM_W-1:0] io_mux;
    logic [NUM_WRITE_PORTS-1:0][RM_W-1:0] result_mux;
    logic [GRID_NUM_ROWS-1:0] io_inp_map;
    logic [GRID_NUM_ROWS-1:0][XLEN-1:0] input_const;
  } rca_active_cfg_t;
  function automatic logic cfg_addr_ok(rca_cfg_field_t f, logic [CFG_ADDR_W-1:0] a);
    return f == SRC_REG ? 32'(a) < NUM_READ_PORTS :
           f == DEST_REG ? 32'(a) < NUM_WRITE_PORTS :
           f == GRID_MUX ? 32'(a) < NUM_GRID_MUXES :
           f == IO_MUX ? 32'(a) < GRID_NUM_ROWS :
           f == RESULT_MUX ? 32'(a) < NUM_WRITE_PORTS :
           f == IO_INP_MAP ? 1'b1 :
           f == INPUT_CONST ? 32'(a) < GRID_NUM_ROWS : 1'b0;
  endfunction
endpackage

// File: rtl/rca_config_bank_if.sv
// rca_config_bank_if: config-write, commit, use-tracking and active-read signals of the bank
interface rca_config_bank_if;
  import rca_config_bank_pkg::*;
  logic cfg_valid;
  logic cfg_ready;
  logic [RCA_W-1:0] cfg_rca;
  rca_cfg_field_t cfg_field;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [XLEN-1:0] cfg_data;
  logic cfg_err;
  logic commit_req;
  logic [RCA_W-1:0] commit_rca;
  logic [NUM_RCAS-1:0] commit_pending;
  logic use_issue;
  logic [RCA_W-1:0] use_rca;
  logic use_ready;
  logic use_complete;
  logic [RCA_W-1:0] complete_rca;
  logic [RCA_W-1:0] rd_rca;
  rca_active_cfg_t active_cfg;
  modport master (
    output cfg_valid, cfg_rca, cfg_field, cfg_addr, cfg_data, commit_req, commit_rca,
           use_issue, use_rca, use_complete, complete_rca, rd_rca,
    input cfg_ready, cfg_err, commit_pending, use_ready, active_cfg
  );
  modport slave (
    input cfg_valid, cfg_rca, cfg_field, cfg_addr, cfg_data, commit_req, commit_rca,
          use_issue, use_rca, use_complete, complete_rca, rd_rca,
    output cfg_ready, cfg_err, commit_pending, use_ready, active_cfg
  );
endinterface

// File: rtl/rca_config_bank_pair.sv
// rca_cfg_bank_pair: shadow bank written by config writes, active bank loaded from shadow on copy
module rca_cfg_bank_pair
  import rca_config_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_en_i,
  input  rca_cfg_field_t field_i,
  input  logic [CFG_ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  input  logic copy_i,
  output rca_active_cfg_t active_o
);
  rca_active_cfg_t shadow_q, shadow_d, active_q, active_d;
  // apply an in-range write to the addressed shadow element; active follows shadow only on copy
  always_comb begin
    shadow_d = shadow_q;
    active_d = copy_i ? shadow_q : active_q;
    if (wr_en_i)
      case (field_i)
        SRC_REG: shadow_d.src_reg[addr_i[SRC_AW-1:0]] = data_i[4:0];
        DEST_REG: shadow_d.dest_reg[addr_i[WP_AW-1:0]] = data_i[4:0];
        GRID_MUX: shadow_d.grid_mux[addr_i[GM_AW-1:0]] = data_i[GM_W-1:0];
        IO_MUX: shadow_d.io_mux[addr_i[ROW_AW-1:0]] = data_i[IOM_W-1:0];
        RESULT_MUX: shadow_d.result_mux[addr_i[WP_AW-1:0]] = data_i[RM_W-1:0];
        IO_INP_MAP: shadow_d.io_inp_map = data_i[GRID_NUM_ROWS-1:0];
        INPUT_CONST: shadow_d.input_const[addr_i[ROW_AW-1:0]] = data_i;
        default: ;
      endcase
  end
  // bank registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  assign active_o = active_q;
endmodule

// File: rtl/rca_config_bank.sv
// rca_config_bank: per-RCA double-buffered config with drain-then-commit control
module rca_config_bank
  import rca_config_bank_pkg::*;
(
  input logic clk,
  input logic rst,
  rca_config_bank_if.slave bus
);
  logic [CNT_W-1:0] cnt [NUM_RCAS];
  rca_active_cfg_t active [NUM_RCAS];
  logic [NUM_RCAS-1:0] pending, copy, wr_en;
  logic cfg_acc, cfg_ok, cfg_err_q, cfg_err_d;
  assign bus.cfg_ready = !(pending[bus.cfg_rca] && cnt[bus.cfg_rca] == '0);
  assign cfg_acc = bus.cfg_valid && bus.cfg_ready;
  assign cfg_ok = cfg_addr_ok(bus.cfg_field, bus.cfg_addr);
  assign cfg_err_d = cfg_acc && !cfg_ok;
  assign bus.use_ready = !pending[bus.use_rca] && cnt[bus.use_rca] < CNT_MAX;
  assign bus.commit_pending = pending;
  assign bus.cfg_err = cfg_err_q;
  assign bus.active_cfg = active[bus.rd_rca];
  // one-cycle pulse for accepted writes that were dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) cfg_err_q <= 1'b0;
    else cfg_err_q <= cfg_err_d;
  for (genvar r = 0; r < NUM_RCAS; r++) begin : g_rca
    commit_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic inc, dec;
    assign inc = bus.use_issue && bus.use_rca == RCA_W'(r);
    assign dec = bus.use_complete && bus.complete_rca == RCA_W'(r);
    assign cnt[r] = count_q;
    assign pending[r] = state_q == PENDING;
    assign copy[r] = pending[r] && count_q == '0;
    assign wr_en[r] = cfg_acc && cfg_ok && bus.cfg_rca == RCA_W'(r);
    // in-flight tracking (saturating both ends) and commit FSM next state
    always_comb begin
      count_d = inc == dec ? count_q :
                inc ? (count_q == CNT_MAX ? count_q : count_q + 1'b1) :
                (count_q == '0 ? count_q : count_q - 1'b1);
      state_d = pending[r] ? (copy[r] ? IDLE : PENDING) :
                (bus.commit_req && bus.commit_rca == RCA_W'(r) ? PENDING : IDLE);
    end
    // commit FSM and counter registers
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
      end
    rca_cfg_bank_pair u_pair (
      .clk(clk),
      .rst(rst),
      .wr_en_i(wr_en[r]),
      .field_i(bus.cfg_field),
      .addr_i(bus.cfg_addr),
      .data_i(bus.cfg_data),
      .copy_i(copy[r]),
      .active_o(active[r])
    );
  end
endmodule

// File: tb/tb_rca_config_bank.sv
// tb_rca_config_bank: directed table-driven and sequence checks of the RCA config bank
module tb_rca_config_bank;
  import rca_config_bank_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  rca_config_bank_if bus();
  rca_config_bank dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    rca_cfg_field_t field;
    int addr;
    logic [31:0] data;
    logic err;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] get(rca_active_cfg_t c, rca_cfg_field_t f, int a);
    case (f)
      SRC_REG: return 32'(c.src_reg[a[2:0]]);
      DEST_REG: return 32'(c.dest_reg[a[0]]);
      GRID_MUX: return 32'(c.grid_mux[a[3:0]]);
      IO_MUX: return 32'(c.io_mux[a[1:0]]);
      RESULT_MUX: return 32'(c.result_mux[a[0]]);
      IO_INP_MAP: return 32'(c.io_inp_map);
      INPUT_CONST: return c.input_const[a[1:0]];
      default: return 32'h0;
    endcase
  endfunction
  task automatic write(input int rca, input rca_cfg_field_t f, input int a, input logic [31:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_rca = RCA_W'(rca);
    bus.cfg_field = f;
    bus.cfg_addr = CFG_ADDR_W'(a);
    bus.cfg_data = d;
  endtask
  task automatic commit(input int rca);
    bus.commit_req = 1'b1;
    bus.commit_rca = RCA_W'(rca);
    tick();
    bus.commit_req = 1'b0;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{SRC_REG, 4, 32'hFFFF_FFFF, 1'b0, 32'h1F};
    tbl[1] = '{DEST_REG, 1, 32'h13, 1'b0, 32'h13};
    tbl[2] = '{GRID_MUX, 15, 32'h5, 1'b0, 32'h5};
    tbl[3] = '{GRID_MUX, 16, 32'h7, 1'b1, 32'h0};
    tbl[4] = '{IO_MUX, 3, 32'h6, 1'b0, 32'h2};
    tbl[5] = '{RESULT_MUX, 0, 32'h3, 1'b0, 32'h3};
    tbl[6] = '{IO_INP_MAP, 9, 32'hA, 1'b0, 32'hA};
    tbl[7] = '{INPUT_CONST, 0, 32'h1234_5678, 1'b0, 32'h1234_5678};
    tbl[8] = '{RESERVED, 0, 32'hFF, 1'b1, 32'h0};
    tbl[9] = '{DEST_REG, 2, 32'h1F, 1'b1, 32'h0};
    tbl[10] = '{INPUT_CONST, 4, 32'h0BAD_0BAD, 1'b1, 32'h0};
    bus.cfg_valid = 0; bus.cfg_rca = 0; bus.cfg_field = SRC_REG; bus.cfg_addr = 0; bus.cfg_data = 0;
    bus.commit_req = 0; bus.commit_rca = 0; bus.use_issue = 0; bus.use_rca = 0;
    bus.use_complete = 0; bus.complete_rca = 0; bus.rd_rca = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("rst_use_ready", 32'(bus.use_ready), 1);
    chk("rst_pending", 32'(bus.commit_pending), 0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 0);
    chk("rst_active_dest0", get(bus.active_cfg, DEST_REG, 0), 0);
    // basic write + commit latency on rca1
    write(1, INPUT_CONST, 2, 32'hDEAD_BEEF);
    tick();
    bus.cfg_valid = 0;
    bus.commit_req = 1; bus.commit_rca = 1; bus.rd_rca = 1;
    #1;
    chk("b_cfg_err", 32'(bus.cfg_err), 0);
    chk("b_shadow_only", get(bus.active_cfg, INPUT_CONST, 2), 0);
    tick();
    bus.commit_req = 0;
    chk("b_pending", 32'(bus.commit_pending), 32'h2);
    chk("b_not_yet", get(bus.active_cfg, INPUT_CONST, 2), 0);
    tick();
    chk("b_const2", get(bus.active_cfg, INPUT_CONST, 2), 32'hDEAD_BEEF);
    chk("b_pending_clr", 32'(bus.commit_pending), 0);
    bus.rd_rca = 0;
    #1;
    chk("b_rca0_const2", get(bus.active_cfg, INPUT_CONST, 2), 0);
    // table of writes to rca0 with error pulses
    for (int i = 0; i < 11; i++) begin
      write(0, tbl[i].field, tbl[i].addr, tbl[i].data);
      tick();
      bus.cfg_valid = 0;
      chk($sformatf("t%0d_err", i), 32'(bus.cfg_err), 32'(tbl[i].err));
      tick();
      chk($sformatf("t%0d_err_pulse", i), 32'(bus.cfg_err), 0);
    end
    commit(0);
    for (int i = 0; i < 11; i++)
      if (!tbl[i].err)
        chk($sformatf("t%0d_val", i), get(bus.active_cfg, tbl[i].field, tbl[i].addr), tbl[i].exp);
    chk("t_gm0_untouched", get(bus.active_cfg, GRID_MUX, 0), 0);
    chk("t_dest0_untouched", get(bus.active_cfg, DEST_REG, 0), 0);
    // commit on rca2 waits for three in-flight uses
    bus.use_issue = 1; bus.use_rca = 2;
    tick(); tick(); tick();
    bus.use_issue = 0;
    write(2, DEST_REG, 0, 32'h7);
    bus.commit_req = 1; bus.commit_rca = 2; bus.rd_rca = 2;
    tick();
    bus.commit_req = 0; bus.cfg_valid = 0;
    chk("c_pending", 32'(bus.commit_pending), 32'h4);
    chk("c_use_ready", 32'(bus.use_ready), 0);
    chk("c_cfg_ready_busy", 32'(bus.cfg_ready), 1);
    bus.use_complete = 1; bus.complete_rca = 2;
    tick(); tick();
    chk("c_held_pending", 32'(bus.commit_pending), 32'h4);
    chk("c_held_active", get(bus.active_cfg, DEST_REG, 0), 0);
    tick();
    bus.use_complete = 0;
    chk("c_drained_pending", 32'(bus.commit_pending), 32'h4);
    chk("c_drained_active", get(bus.active_cfg, DEST_REG, 0), 0);
    chk("c_cfg_ready_copy", 32'(bus.cfg_ready), 0);
    tick();
    chk("c_copied", get(bus.active_cfg, DEST_REG, 0), 32'h7);
    chk("c_pending_clr", 32'(bus.commit_pending), 0);
    chk("c_use_ready_back", 32'(bus.use_ready), 1);
    // rca0 fills to MAX_INFLIGHT
    bus.use_issue = 1; bus.use_rca = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("d_ready_%0d", i), 32'(bus.use_ready), 32'(i < 7));
    end
    bus.use_rca = 1;
    #1;
    chk("d_other_rca", 32'(bus.use_ready), 1);
    bus.use_rca = 0; bus.use_complete = 1; bus.complete_rca = 0;
    tick();
    chk("d_both_hold", 32'(bus.use_ready), 0);
    bus.use_issue = 0;
    tick();
    chk("d_one_freed", 32'(bus.use_ready), 1);
    for (int i = 0; i < 6; i++) tick();
    bus.use_complete = 0;
    // commit with same-cycle write, then a write during the copy cycle
    bus.rd_rca = 1;
    write(1, IO_MUX, 1, 32'h3);
    bus.commit_req = 1; bus.commit_rca = 1;
    tick();
    bus.commit_req = 0;
    write(1, IO_MUX, 0, 32'h1);
    #1;
    chk("e_cfg_ready_low", 32'(bus.cfg_ready), 0);
    tick();
    chk("e_pending_clr", 32'(bus.commit_pending), 0);
    chk("e_merged_write", get(bus.active_cfg, IO_MUX, 1), 32'h3);
    chk("e_late_not_copied", get(bus.active_cfg, IO_MUX, 0), 0);
    chk("e_cfg_ready_back", 32'(bus.cfg_ready), 1);
    tick();
    bus.cfg_valid = 0;
    chk("e_late_shadow_only", get(bus.active_cfg, IO_MUX, 0), 0);
    chk("e_late_no_err", 32'(bus.cfg_err), 0);
    commit(1);
    chk("e_late_committed", get(bus.active_cfg, IO_MUX, 0), 32'h1);
    // asynchronous reset while rca3 commit is pending with two uses
    bus.use_issue = 1; bus.use_rca = 3;
    tick(); tick();
    bus.use_issue = 0;
    bus.commit_req = 1; bus.commit_rca = 3;
    tick();
    bus.commit_req = 0; bus.cfg_rca = 3;
    chk("f_pending", 32'(bus.commit_pending), 32'h8);
    chk("f_use_ready", 32'(bus.use_ready), 0);
    rst = 1'b1;
    #1;
    chk("f_async_pending", 32'(bus.commit_pending), 0);
    chk("f_async_active", get(bus.active_cfg, INPUT_CONST, 2), 0);
    tick();
    chk("f_use_ready", 32'(bus.use_ready), 1);
    chk("f_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("f_cfg_err", 32'(bus.cfg_err), 0);
    chk("f_active_io", get(bus.active_cfg, IO_MUX, 1), 0);
    rst = 1'b0;
    tick();
    chk("f_after_pending", 32'(bus.commit_pending), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
